regfile_mp: RTL and testbench

- Parametrised multi-port register file; successor to the single-write, dual-read MIPS register bank in the ARC datapath.
- Adds:
  - configurable width, depth and port counts
  - hardwired zero register
  - write-to-read bypass
  - deterministic write-conflict priority
  - per-register pending scoreboard for load-use hazard detection
- Sits between decode (read ports, scoreboard set) and writeback (write ports, scoreboard clear).

---
 rtl/regfile_pkg.sv | 18 +
 rtl/regfile_wr_arb.sv | 47 ++++
 rtl/regfile_mp.sv | 138 +++++++++++++
 tb/tb_regfile_mp.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared definitions for the multi-port register file: default geometry,
// storage/address types at that default geometry, and the MIPS register
// index constants used by decode and the bench.
package regfile_pkg;

    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 32;
    localparam int NREGS     = 2 ** RF_ADDR_W;

    typedef logic [RF_ADDR_W-1:0] reg_addr_t;
    typedef logic [RF_DATA_W-1:0] reg_data_t;

    localparam int REG_ZERO = 0;
    localparam int REG_SP   = 29;
    localparam int REG_RA   = 31;

endpackage

// File: rtl/regfile_wr_arb.sv
// regfile_wr_arb
// Picks the winning write port for one register address. Used both for the
// storage update and for the read bypass, so both paths apply the same
// priority: among enabled ports hitting i_addr, the highest index wins.
// Writes to register 0 are filtered here when ZERO_REG=1.
//   i_addr        address this instance arbitrates for
//   i_wr_en       per-port write enables
//   i_wr_addr     packed write addresses, port j at [j*ADDR_W +: ADDR_W]
//   i_wr_data     packed write data, port j at [j*DATA_W +: DATA_W]
//   o_win_onehot  one-hot winning port (all zero when nothing hits)
//   o_win_data    data of the winning port (zero when nothing hits)
module regfile_wr_arb
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int N_WR     = 1,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic [ADDR_W-1:0]      i_addr,
    input  logic [N_WR-1:0]        i_wr_en,
    input  logic [N_WR*ADDR_W-1:0] i_wr_addr,
    input  logic [N_WR*DATA_W-1:0] i_wr_data,
    output logic [N_WR-1:0]        o_win_onehot,
    output logic [DATA_W-1:0]      o_win_data
);

    logic addr_is_zero;

    assign addr_is_zero = ZERO_REG && (i_addr == ADDR_W'(REG_ZERO));

    // Later ports overwrite earlier matches, which gives highest-index priority.
    always_comb begin
        o_win_onehot = '0;
        o_win_data   = '0;
        if (!addr_is_zero) begin
            for (int j = 0; j < N_WR; j++) begin
                if (i_wr_en[j] && (i_wr_addr[j*ADDR_W +: ADDR_W] == i_addr)) begin
                    o_win_onehot    = '0;
                    o_win_onehot[j] = 1'b1;
                    o_win_data      = i_wr_data[j*DATA_W +: DATA_W];
                end
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp
// Parametrised multi-port register file with optional hardwired zero
// register, write-to-read bypass and a per-register pending scoreboard for
// load-use hazard detection.
//   i_clk, i_rst_n  clock (rising edge), asynchronous active-low reset
//   i_rd_addr       packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   o_rd_data       packed read data, port k at [k*DATA_W +: DATA_W]
//   o_rd_busy       per read port: addressed register still pending
//   i_wr_en/addr/data  write ports (writeback); also clear pending bits
//   i_sb_set, i_sb_addr  mark a register pending (long-latency issue)
//   o_pending       registered pending vector, bit r = register r
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int N_RD     = 2,
    parameter int N_WR     = 1,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [N_RD*ADDR_W-1:0] i_rd_addr,
    output logic [N_RD*DATA_W-1:0] o_rd_data,
    output logic [N_RD-1:0]        o_rd_busy,
    input  logic [N_WR-1:0]        i_wr_en,
    input  logic [N_WR*ADDR_W-1:0] i_wr_addr,
    input  logic [N_WR*DATA_W-1:0] i_wr_data,
    input  logic                   i_sb_set,
    input  logic [ADDR_W-1:0]      i_sb_addr,
    output logic [2**ADDR_W-1:0]   o_pending
);

    localparam int N_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [N_REGS];
    logic [DATA_W-1:0] regs_d [N_REGS];
    logic [N_REGS-1:0] pending_q;
    logic [N_REGS-1:0] pending_d;

    logic [N_WR-1:0]   st_onehot [N_REGS];
    logic [DATA_W-1:0] st_data   [N_REGS];

    logic [ADDR_W-1:0] rd_addr    [N_RD];
    logic [N_WR-1:0]   rd_onehot  [N_RD];
    logic [DATA_W-1:0] rd_wr_data [N_RD];

    // One arbiter per register decides what (if anything) lands there.
    for (genvar r = 0; r < N_REGS; r++) begin : g_st_arb
        regfile_wr_arb #(
            .ADDR_W  (ADDR_W),
            .DATA_W  (DATA_W),
            .N_WR    (N_WR),
            .ZERO_REG(ZERO_REG)
        ) u_arb (
            .i_addr      (ADDR_W'(r)),
            .i_wr_en     (i_wr_en),
            .i_wr_addr   (i_wr_addr),
            .i_wr_data   (i_wr_data),
            .o_win_onehot(st_onehot[r]),
            .o_win_data  (st_data[r])
        );
    end

    // One arbiter per read port finds the same-cycle write to forward.
    for (genvar k = 0; k < N_RD; k++) begin : g_rd_arb
        assign rd_addr[k] = i_rd_addr[k*ADDR_W +: ADDR_W];

        regfile_wr_arb #(
            .ADDR_W  (ADDR_W),
            .DATA_W  (DATA_W),
            .N_WR    (N_WR),
            .ZERO_REG(ZERO_REG)
        ) u_arb (
            .i_addr      (rd_addr[k]),
            .i_wr_en     (i_wr_en),
            .i_wr_addr   (i_wr_addr),
            .i_wr_data   (i_wr_data),
            .o_win_onehot(rd_onehot[k]),
            .o_win_data  (rd_wr_data[k])
        );
    end

    // Next storage and scoreboard state. A same-cycle set beats a clear
    // because a new producer has been issued for that register.
    always_comb begin
        pending_d = pending_q;
        for (int r = 0; r < N_REGS; r++) begin
            regs_d[r] = (|st_onehot[r]) ? st_data[r] : regs_q[r];
            if (|st_onehot[r]) begin
                pending_d[r] = 1'b0;
            end
            if (i_sb_set && (i_sb_addr == ADDR_W'(r))) begin
                pending_d[r] = 1'b1;
            end
        end
        if (ZERO_REG) begin
            pending_d[REG_ZERO] = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int r = 0; r < N_REGS; r++) begin
                regs_q[r] <= '0;
            end
            pending_q <= '0;
        end else begin
            for (int r = 0; r < N_REGS; r++) begin
                regs_q[r] <= regs_d[r];
            end
            pending_q <= pending_d;
        end
    end

    // Combinational read ports. A forwarded write also hides the pending
    // bit, since the result is arriving this very cycle.
    always_comb begin
        o_rd_data = '0;
        o_rd_busy = '0;
        for (int k = 0; k < N_RD; k++) begin
            if (ZERO_REG && (rd_addr[k] == ADDR_W'(REG_ZERO))) begin
                o_rd_data[k*DATA_W +: DATA_W] = '0;
                o_rd_busy[k]                  = 1'b0;
            end else if (BYPASS && (|rd_onehot[k])) begin
                o_rd_data[k*DATA_W +: DATA_W] = rd_wr_data[k];
                o_rd_busy[k]                  = 1'b0;
            end else begin
                o_rd_data[k*DATA_W +: DATA_W] = regs_q[rd_addr[k]];
                o_rd_busy[k]                  = pending_q[rd_addr[k]];
            end
        end
    end

    assign o_pending = pending_q;

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp
// Directed bench for regfile_mp. The main instance has two write ports and
// bypass enabled; a second instance with bypass disabled and one write port
// shares port 0 of the stimulus to show the non-forwarding behaviour.
module tb_regfile_mp;
    import regfile_pkg::*;

    logic        clk;
    logic        rstN;
    logic [9:0]  rdAddr;
    logic [63:0] rdData;
    logic [1:0]  rdBusy;
    logic [1:0]  wrEn;
    logic [9:0]  wrAddr;
    logic [63:0] wrData;
    logic        sbSet;
    logic [4:0]  sbAddr;
    logic [31:0] pending;

    logic [63:0] nbRdData;
    logic [1:0]  nbRdBusy;
    logic [31:0] nbPending;

    int errors = 0;
    int checks = 0;

    regfile_mp #(
        .DATA_W(32), .ADDR_W(5), .N_RD(2), .N_WR(2), .ZERO_REG(1'b1), .BYPASS(1'b1)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rstN),
        .i_rd_addr(rdAddr),
        .o_rd_data(rdData),
        .o_rd_busy(rdBusy),
        .i_wr_en  (wrEn),
        .i_wr_addr(wrAddr),
        .i_wr_data(wrData),
        .i_sb_set (sbSet),
        .i_sb_addr(sbAddr),
        .o_pending(pending)
    );

    regfile_mp #(
        .DATA_W(32), .ADDR_W(5), .N_RD(2), .N_WR(1), .ZERO_REG(1'b1), .BYPASS(1'b0)
    ) dutNb (
        .i_clk    (clk),
        .i_rst_n  (rstN),
        .i_rd_addr(rdAddr),
        .o_rd_data(nbRdData),
        .o_rd_busy(nbRdBusy),
        .i_wr_en  (wrEn[0]),
        .i_wr_addr(wrAddr[4:0]),
        .i_wr_data(wrData[31:0]),
        .i_sb_set (sbSet),
        .i_sb_addr(sbAddr),
        .o_pending(nbPending)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs on the falling edge, then settle for sampling.
    task automatic applyStimulus(input logic [1:0] we,
                                 input logic [4:0] wa0, input logic [31:0] wd0,
                                 input logic [4:0] wa1, input logic [31:0] wd1,
                                 input logic [4:0] ra0, input logic [4:0] ra1,
                                 input logic set, input logic [4:0] sa);
        @(negedge clk);
        wrEn   = we;
        wrAddr = {wa1, wa0};
        wrData = {wd1, wd0};
        rdAddr = {ra1, ra0};
        sbSet  = set;
        sbAddr = sa;
        #1;
    endtask

    initial begin
        rstN   = 1'b0;
        wrEn   = '0;
        wrAddr = '0;
        wrData = '0;
        sbSet  = 1'b0;
        sbAddr = '0;
        rdAddr = {5'd0, 5'd5};
        #3;
        checkOutput("reset_rd_data", rdData, 64'h0);
        checkOutput("reset_busy", {62'h0, rdBusy}, 64'h0);
        checkOutput("reset_pending", {32'h0, pending}, 64'h0);
        @(negedge clk);
        rstN = 1'b1;

        // Write r5 and mark r8 pending, then reset mid-cycle.
        applyStimulus(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 5'd5, 5'd0, 1'b1, 5'd8);
        checkOutput("bypass_r5", rdData[31:0], 64'hDEADBEEF);
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd5, 5'd8, 1'b0, 5'd0);
        checkOutput("stored_r5", rdData[31:0], 64'hDEADBEEF);
        checkOutput("pending_r8", {32'h0, pending}, 64'h100);
        checkOutput("busy_r8", {62'h0, rdBusy}, 64'h2);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("midreset_r5", rdData[31:0], 64'h0);
        checkOutput("midreset_pending", {32'h0, pending}, 64'h0);
        checkOutput("midreset_busy", {62'h0, rdBusy}, 64'h0);
        @(negedge clk);
        rstN = 1'b1;

        // Basic write/read and zero register.
        applyStimulus(2'b01, 5'd7, 32'h12345678, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0);
        applyStimulus(2'b01, 5'd0, 32'hFFFFFFFF, 5'd0, 32'h0, 5'd7, 5'd0, 1'b0, 5'd0);
        checkOutput("read_r7", rdData[31:0], 64'h12345678);
        checkOutput("read_r0_during_write", rdData[63:32], 64'h0);
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd7, 1'b0, 5'd0);
        checkOutput("read_r0_after_write", rdData[31:0], 64'h0);
        checkOutput("read_r7_port1", rdData[63:32], 64'h12345678);

        // Bypass versus no-bypass.
        applyStimulus(2'b01, 5'd9, 32'hA5A5A5A5, 5'd0, 32'h0, 5'd9, 5'd9, 1'b0, 5'd0);
        checkOutput("bypass_r9_both", rdData, 64'hA5A5A5A5_A5A5A5A5);
        checkOutput("nobypass_r9_old", nbRdData[31:0], 64'h0);
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 5'd0, 1'b0, 5'd0);
        checkOutput("nobypass_r9_stored", nbRdData[31:0], 64'hA5A5A5A5);

        // Write conflict: port 1 wins.
        applyStimulus(2'b11, 5'd3, 32'h1, 5'd3, 32'h2, 5'd3, 5'd0, 1'b0, 5'd0);
        checkOutput("conflict_bypass_r3", rdData[31:0], 64'h2);
        applyStimulus(2'b11, 5'd10, 32'hAA, 5'(REG_RA), 32'hBB, 5'd3, 5'd0, 1'b0, 5'd0);
        checkOutput("conflict_stored_r3", rdData[31:0], 64'h2);
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd10, 5'(REG_RA), 1'b0, 5'd0);
        checkOutput("dual_write_r10_r31", rdData, {32'hBB, 32'hAA});

        // Scoreboard set, then clear by write.
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd4, 5'd0, 1'b1, 5'd4);
        checkOutput("sb_set_sameCycle_busy", {62'h0, rdBusy}, 64'h0);
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd4, 5'd0, 1'b0, 5'd0);
        checkOutput("sb_pending_r4", {32'h0, pending}, 64'h10);
        checkOutput("sb_busy_r4", {62'h0, rdBusy}, 64'h1);
        applyStimulus(2'b01, 5'd4, 32'h55, 5'd0, 32'h0, 5'd4, 5'd0, 1'b0, 5'd0);
        checkOutput("sb_write_busy_bypassed", {62'h0, rdBusy}, 64'h0);
        checkOutput("sb_write_data_r4", rdData[31:0], 64'h55);
        checkOutput("sb_write_busy_nobypass", {62'h0, nbRdBusy}, 64'h1);
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd4, 5'd0, 1'b0, 5'd0);
        checkOutput("sb_cleared_pending", {32'h0, pending}, 64'h0);

        // Set/clear collision on r6: set wins; then set to r0 is ignored.
        applyStimulus(2'b01, 5'd6, 32'h77, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd6);
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd6, 1'b1, 5'd0);
        checkOutput("collide_r6_data", rdData[63:32], 64'h77);
        checkOutput("collide_r6_pending", {32'h0, pending}, 64'h40);
        checkOutput("collide_r6_busy", {62'h0, rdBusy}, 64'h2);
        applyStimulus(2'b10, 5'd0, 32'h0, 5'd6, 32'h88, 5'd0, 5'd6, 1'b0, 5'd0);
        checkOutput("r0_never_pending", {32'h0, pending}, 64'h40);
        checkOutput("r0_busy", {62'h0, rdBusy}, 64'h0);
        applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd6, 1'b0, 5'd0);
        checkOutput("port1_clears_r6", {32'h0, pending}, 64'h0);
        checkOutput("port1_data_r6", rdData[63:32], 64'h88);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
